// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the mem_arbiter slice: default bus geometry,
// protected-region size, memory latency and the port identifier.
package mem_arbiter_pkg;

  localparam int DEF_WIDTH        = 32;
  localparam int DEF_ADDR_WIDTH   = 10;
  localparam int DEF_DATA_OFFSET  = 256;
  localparam int DEF_MEMORY_DEPTH = 1 << DEF_ADDR_WIDTH;
  localparam int DEF_PROG_WORDS   = DEF_DATA_OFFSET / 4;
  localparam int DEF_MEM_LAT      = 1;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

endpackage

// File: rtl/mem_arbiter_rr_grant.sv
// Two-input round-robin picker: a lone request wins outright, a tie goes to
// the port that was not granted last.
module rr_grant
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  port_e      last,
  output logic [1:0] grant
);

  always_comb begin
    // NOTE: default assignment first so every path drives grant and no latch is inferred.
    grant = req;
    if (req == 2'b11) begin
      grant = (last == PORT_D) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and fixed-latency sequencer putting the fetch and data
// ports onto the single-port mem bank, with a write-protected program region.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PROG_WORDS = DEF_PROG_WORDS,
  parameter int MEM_LAT    = DEF_MEM_LAT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ack,
  output logic [WIDTH-1:0]      i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0]      d_wdata,
  output logic                  d_ack,
  output logic                  d_err,
  output logic [WIDTH-1:0]      d_rdata,
  output logic                  mem_mode,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e      state;
  port_e       last_grant;
  port_e       cur_port;
  logic        cur_we;
  logic        cur_err;
  logic [1:0]  cnt;
  logic [1:0]  grant;
  logic        d_prot;

  rr_grant u_rr_grant (
    .req   ({d_req, i_req}),
    .last  (last_grant),
    .grant (grant)
  );

  assign d_prot = d_we && (32'(d_addr) < 32'(PROG_WORDS));

  // NOTE: asynchronous active-high reset in the sensitivity list; all state uses <= so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= PORT_D;
      cur_port   <= PORT_I;
      cur_we     <= 1'b0;
      cur_err    <= 1'b0;
      cnt        <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      d_err      <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      mem_mode   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      d_err <= 1'b0;

      unique case (state)
        IDLE: begin
          // The memory-side registers double as the request latch, so the
          // address is already on the bus for the whole ISSUE cycle.
          if (grant[1]) begin
            cur_port  <= PORT_D;
            cur_we    <= d_we;
            cur_err   <= d_prot;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_mode  <= d_we && !d_prot;
            state     <= ISSUE;
          end else if (grant[0]) begin
            cur_port  <= PORT_I;
            cur_we    <= 1'b0;
            cur_err   <= 1'b0;
            mem_addr  <= i_addr;
            mem_mode  <= 1'b0;
            state     <= ISSUE;
          end
        end

        ISSUE: begin
          cnt   <= 2'(MEM_LAT - 1);
          state <= WAIT;
        end

        WAIT: begin
          if (cnt == 2'd0) begin
            if (!cur_we) begin
              if (cur_port == PORT_I) i_rdata <= mem_rdata;
              else                    d_rdata <= mem_rdata;
            end
            mem_mode <= 1'b0;
            i_ack    <= (cur_port == PORT_I);
            d_ack    <= (cur_port == PORT_D);
            d_err    <= (cur_port == PORT_D) && cur_err;
            state    <= RESP;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end

        RESP: begin
          last_grant <= cur_port;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a latency-1 memory model behind the default
// instance and a latency-3 read model behind a MEM_LAT=3 instance.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW    = DEF_ADDR_WIDTH;
  localparam int DW    = DEF_WIDTH;
  localparam int PW    = DEF_PROG_WORDS;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;

  logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          i_ack, d_ack, d_err, mem_mode;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;

  logic          b_i_req = 1'b0;
  logic [AW-1:0] b_i_addr = '0;
  logic          b_d_req = 1'b0, b_d_we = 1'b0;
  logic [AW-1:0] b_d_addr = '0;
  logic [DW-1:0] b_d_wdata = '0;
  logic          b_i_ack, b_d_ack, b_d_err, b_mem_mode;
  logic [DW-1:0] b_i_rdata, b_d_rdata, b_mem_wdata;
  logic [AW-1:0] b_mem_addr;
  logic [DW-1:0] b_mem_rdata = '0, b_p1 = '0, b_p2 = '0;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] bank [0:DEPTH-1];
  bit            bank_ready = 1'b0;

  mem_arbiter u_dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .mem_mode(mem_mode), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.MEM_LAT(3)) u_dut_lat3 (
    .clk(clk), .reset(reset),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_ack(b_i_ack), .i_rdata(b_i_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_ack(b_d_ack), .d_err(b_d_err), .d_rdata(b_d_rdata),
    .mem_mode(b_mem_mode), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port bank: one-cycle registered read, write when mode is high.
  always @(posedge clk) begin
    if (!bank_ready) begin
      for (int j = 0; j < DEPTH; j++) bank[j] <= 32'hA000_0000 + 32'(j);
      bank_ready <= 1'b1;
    end else if (mem_mode) begin
      bank[mem_addr] <= mem_wdata;
    end
    mem_rdata <= bank[mem_addr];
  end

  // Three-cycle read-only model: word = 0xB0000000 + address.
  always @(posedge clk) begin
    b_p1        <= 32'hB000_0000 + 32'(b_mem_addr);
    b_p2        <= b_p1;
    b_mem_rdata <= b_p2;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Steps cycles until the selected ack (0 fetch, 1 data, 2 lat3 fetch); cyc = -1 on timeout.
  task automatic wait_ack(input int which, output int cyc, output logic err);
    cyc = -1;
    err = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if ((which == 0 && i_ack) || (which == 1 && d_ack) || (which == 2 && b_i_ack)) begin
        cyc = c;
        err = d_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if ({i_ack, d_ack, d_err, mem_mode} !== 4'b0000)
      begin failures++; $display("FAIL reset_flags: got %b expected 0000", {i_ack, d_ack, d_err, mem_mode}); end
    checks++;
    if ({mem_addr, mem_wdata} !== '0)
      begin failures++; $display("FAIL reset_mem_bus: got addr %0h wdata %0h expected 0", mem_addr, mem_wdata); end
    checks++;
    if ({i_rdata, d_rdata} !== '0)
      begin failures++; $display("FAIL reset_rdata: got i %0h d %0h expected 0", i_rdata, d_rdata); end
    checks++;
    if ({b_i_ack, b_mem_mode} !== 2'b00)
      begin failures++; $display("FAIL reset_lat3: got %b expected 00", {b_i_ack, b_mem_mode}); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    i_addr = '0;
    i_req  = 1'b1;
    tick();
    checks++;
    if (mem_addr !== '0 || mem_mode !== 1'b0 || i_ack !== 1'b0)
      begin failures++; $display("FAIL fetch_issue: got addr %0h mode %b ack %b expected 0 0 0", mem_addr, mem_mode, i_ack); end
    tick();
    checks++;
    if (i_ack !== 1'b0)
      begin failures++; $display("FAIL fetch_early_ack: got %b expected 0", i_ack); end
    tick();
    checks++;
    if (i_ack !== 1'b1 || d_ack !== 1'b0)
      begin failures++; $display("FAIL fetch_ack: got i %b d %b expected 1 0", i_ack, d_ack); end
    i_req = 1'b0;
    checks++;
    if (i_rdata !== 32'hA000_0000)
      begin failures++; $display("FAIL fetch_rdata: got %h expected a0000000", i_rdata); end
    tick();
    checks++;
    if (i_ack !== 1'b0)
      begin failures++; $display("FAIL fetch_ack_pulse: got %b expected 0", i_ack); end
  endtask

  task automatic test_write_read();
    int          mode_cycles;
    int          ack_cyc;
    logic        err;
    logic [DW-1:0] rdata_before;
    rdata_before = d_rdata;
    mode_cycles  = 0;
    ack_cyc      = -1;
    err          = 1'b0;
    d_addr  = AW'(PW + 5);
    d_wdata = 32'hDEAD_BEEF;
    d_we    = 1'b1;
    d_req   = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (mem_mode) mode_cycles++;
      if (d_ack) begin ack_cyc = c; err = d_err; break; end
    end
    d_req = 1'b0;
    checks++;
    if (ack_cyc !== 3)
      begin failures++; $display("FAIL write_ack_latency: got %0d expected 3", ack_cyc); end
    checks++;
    if (mode_cycles !== 2)
      begin failures++; $display("FAIL write_mode_cycles: got %0d expected 2", mode_cycles); end
    checks++;
    if (err !== 1'b0)
      begin failures++; $display("FAIL write_err: got %b expected 0", err); end
    checks++;
    if (bank[PW+5] !== 32'hDEAD_BEEF)
      begin failures++; $display("FAIL write_bank: got %h expected deadbeef", bank[PW+5]); end
    checks++;
    if (d_rdata !== rdata_before)
      begin failures++; $display("FAIL write_keeps_rdata: got %h expected %h", d_rdata, rdata_before); end
    tick();
    d_we  = 1'b0;
    d_req = 1'b1;
    wait_ack(1, ack_cyc, err);
    d_req = 1'b0;
    checks++;
    if (ack_cyc !== 3 || err !== 1'b0)
      begin failures++; $display("FAIL read_ack: got cyc %0d err %b expected 3 0", ack_cyc, err); end
    checks++;
    if (d_rdata !== 32'hDEAD_BEEF)
      begin failures++; $display("FAIL read_rdata: got %h expected deadbeef", d_rdata); end
    tick();
  endtask

  task automatic test_protected();
    int   mode_cycles;
    int   ack_cyc;
    logic err;
    mode_cycles = 0;
    ack_cyc     = -1;
    err         = 1'b0;
    d_addr  = AW'(2);
    d_wdata = 32'h1234_5678;
    d_we    = 1'b1;
    d_req   = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (mem_mode) mode_cycles++;
      if (d_ack) begin ack_cyc = c; err = d_err; break; end
    end
    d_req = 1'b0;
    d_we  = 1'b0;
    checks++;
    if (ack_cyc !== 3 || err !== 1'b1)
      begin failures++; $display("FAIL prot_ack_err: got cyc %0d err %b expected 3 1", ack_cyc, err); end
    checks++;
    if (mode_cycles !== 0)
      begin failures++; $display("FAIL prot_mode: got %0d write cycles expected 0", mode_cycles); end
    checks++;
    if (bank[2] !== 32'hA000_0002)
      begin failures++; $display("FAIL prot_bank: got %h expected a0000002", bank[2]); end
    tick();
    checks++;
    if (d_err !== 1'b0 || d_ack !== 1'b0)
      begin failures++; $display("FAIL prot_err_pulse: got ack %b err %b expected 0 0", d_ack, d_err); end
  endtask

  task automatic test_back_to_back();
    int   n_acks;
    int   ack_port [6];
    int   ack_cyc  [6];
    n_acks = 0;
    for (int k = 0; k < 6; k++) begin ack_port[k] = -1; ack_cyc[k] = -1; end
    i_addr = AW'(10);
    d_addr = AW'(PW + 10);
    d_we   = 1'b0;
    i_req  = 1'b1;
    d_req  = 1'b1;
    for (int c = 1; c <= 60 && n_acks < 6; c++) begin
      tick();
      if (i_ack) begin ack_port[n_acks] = 0; ack_cyc[n_acks] = c; n_acks++; end
      else if (d_ack) begin ack_port[n_acks] = 1; ack_cyc[n_acks] = c; n_acks++; end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    checks++;
    if (ack_cyc[0] !== 3)
      begin failures++; $display("FAIL rr_first_ack: got %0d expected 3", ack_cyc[0]); end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (ack_port[k] !== (k % 2))
        begin failures++; $display("FAIL rr_order[%0d]: got port %0d expected %0d", k, ack_port[k], k % 2); end
    end
    for (int k = 1; k < 6; k++) begin
      checks++;
      if (ack_cyc[k] - ack_cyc[k-1] !== 4)
        begin failures++; $display("FAIL rr_spacing[%0d]: got %0d expected 4", k, ack_cyc[k] - ack_cyc[k-1]); end
    end
    checks++;
    if (i_rdata !== 32'hA000_000A || d_rdata !== 32'hA000_0000 + 32'(PW + 10))
      begin failures++; $display("FAIL rr_rdata: got i %h d %h expected a000000a %h", i_rdata, d_rdata, 32'hA000_0000 + 32'(PW + 10)); end
    tick();
  endtask

  task automatic test_reset_mid();
    int   ack_cyc;
    logic err;
    logic seen_ack;
    seen_ack = 1'b0;
    d_addr = AW'(PW + 5);
    d_we   = 1'b0;
    d_req  = 1'b1;
    tick();
    tick();
    checks++;
    if (mem_addr !== AW'(PW + 5))
      begin failures++; $display("FAIL mid_in_wait: got addr %0h expected %0h", mem_addr, PW + 5); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({d_ack, d_err, mem_mode, i_ack} !== 4'b0000 || mem_addr !== '0 || d_rdata !== '0 || i_rdata !== '0)
      begin failures++; $display("FAIL mid_async_reset: got flags %b addr %0h d %h i %h expected 0", {d_ack, d_err, mem_mode, i_ack}, mem_addr, d_rdata, i_rdata); end
    d_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (d_ack) seen_ack = 1'b1;
    end
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (d_ack) seen_ack = 1'b1;
    end
    checks++;
    if (seen_ack !== 1'b0)
      begin failures++; $display("FAIL mid_no_ack: got ack %b expected 0", seen_ack); end
    d_req = 1'b1;
    wait_ack(1, ack_cyc, err);
    d_req = 1'b0;
    checks++;
    if (ack_cyc !== 3 || d_rdata !== 32'hDEAD_BEEF)
      begin failures++; $display("FAIL mid_reissue: got cyc %0d rdata %h expected 3 deadbeef", ack_cyc, d_rdata); end
    tick();
  endtask

  task automatic test_top_addr();
    int   ack_cyc;
    logic err;
    i_addr = '1;
    i_req  = 1'b1;
    tick();
    checks++;
    if (mem_addr !== '1)
      begin failures++; $display("FAIL top_issue_addr: got %0h expected %0h", mem_addr, DEPTH - 1); end
    wait_ack(0, ack_cyc, err);
    i_req = 1'b0;
    checks++;
    if (ack_cyc !== 2 || i_rdata !== 32'hA000_0000 + 32'(DEPTH - 1))
      begin failures++; $display("FAIL top_fetch: got cyc %0d rdata %h expected 2 %h", ack_cyc, i_rdata, 32'hA000_0000 + 32'(DEPTH - 1)); end
    tick();
  endtask

  task automatic test_mem_lat3();
    int   ack_cyc;
    logic err;
    b_i_addr = AW'(7);
    b_i_req  = 1'b1;
    wait_ack(2, ack_cyc, err);
    b_i_req = 1'b0;
    checks++;
    if (ack_cyc !== 5)
      begin failures++; $display("FAIL lat3_latency: got %0d expected 5", ack_cyc); end
    checks++;
    if (b_i_rdata !== 32'hB000_0007)
      begin failures++; $display("FAIL lat3_rdata: got %h expected b0000007", b_i_rdata); end
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_write_read();
    test_protected();
    test_back_to_back();
    test_reset_mid();
    test_top_addr();
    test_mem_lat3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the shared single-port `mem` bank. It multiplexes an instruction-fetch port (read-only) and a data port (read/write) onto the memory's `mode`/`addr`/`data_in`/`data_out` interface. Arbitration is round-robin, and each access runs through a fixed-latency request/ack handshake. The arbiter also write-protects the program region loaded at start-up. It sits between the CPU core and `mem`, and is the only driver of the memory's control inputs.

## Interface
- `ADDR_WIDTH`, from `lib/params.vh`: word-address width.
- `WIDTH`, from `lib/params.vh`: data word width.
- `PROG_WORDS`, default `DATA_OFFSET/4`: words `[0, PROG_WORDS)` are write-protected.
- `MEM_LAT`, default 1: memory read latency in cycles, range 1..4.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `i_req`  in  1  fetch request, level.
- `i_addr`  in  ADDR_WIDTH  fetch word address.
- `i_ack`  out  1  one-cycle fetch completion pulse.
- `i_rdata`  out  WIDTH  fetched word; valid from `i_ack` onward.
- `d_req`  in  1  data request, level.
- `d_we`  in  1  1 = write, 0 = read.
- `d_addr`  in  ADDR_WIDTH  data word address.
- `d_wdata`  in  WIDTH  write data.
- `d_ack`  out  1  one-cycle data completion pulse.
- `d_err`  out  1  qualifies `d_ack`: the write was rejected (protected region).
- `d_rdata`  out  WIDTH  read word; valid from `d_ack` onward.
- `mem_mode`  out  1  to `mem.mode`: 0 read, 1 write.
- `mem_addr`  out  ADDR_WIDTH  to `mem.addr`.
- `mem_wdata`  out  WIDTH  to `mem.data_in`.
- `mem_rdata`  in  WIDTH  from `mem.data_out`.

## Operation
- FSM states: `IDLE`, `ISSUE`, `WAIT`, `RESP`.
- **IDLE**
  - Samples `i_req`/`d_req`.
  - If exactly one is high, that port is granted.
  - If both are high, the port not granted last wins. `last_grant` resets to data, so fetch wins the first tie.
  - On a grant, the arbiter latches the winner's address, write enable (fetch is always read) and write data, then moves to `ISSUE`.
- **ISSUE** (1 cycle)
  - Drives `mem_addr`, `mem_wdata` and `mem_mode` from the latched values, then moves to `WAIT`.
  - Protected write (`d_we=1`, `d_addr < PROG_WORDS`): `mem_mode` stays 0, `d_err` is flagged, and the cycle count is unchanged.
- **WAIT**
  - Holds the memory signals for `MEM_LAT` cycles using a down-counter.
  - On the final cycle, captures `mem_rdata` into the granted port's rdata register, reads only. Then moves to `RESP`.
- **RESP** (1 cycle)
  - Pulses the granted port's ack, together with `d_err` if it was flagged.
  - Updates `last_grant`, returns `mem_mode` to 0, and moves to `IDLE`.
- Requester rules:
  - Hold req, address and data stable until ack.
  - Deassert req in the cycle after ack, or it is taken as a new request.
  - A req that drops before ack is still completed; the ack is delivered anyway.
- `mem_mode` is 1 only during `ISSUE`/`WAIT` of an unprotected write. Outside a transaction, `mem_addr` and `mem_wdata` hold their last values.
- rdata registers change only on their own port's read completion. A write does not touch `d_rdata`.

## Timing
- All outputs are registered.
- Reset values: state `IDLE`; `i_ack`, `d_ack`, `d_err`, `mem_mode` = 0; `mem_addr`, `mem_wdata`, `i_rdata`, `d_rdata` = 0; `last_grant` = data.
- Latency: req high at edge k (state `IDLE`) → ack high in cycle k+2+`MEM_LAT`. Default: 3 cycles.
- Throughput: one transaction per 3+`MEM_LAT` cycles.
- Under continuous contention, grants strictly alternate (i, d, i, d, …). No starvation.
- Reset mid-transaction:
  - Returns immediately to `IDLE` and forces `mem_mode` to 0.
  - The aborted write may or may not have landed.
  - No ack is issued for the aborted request.
- Address wrap: none. Addresses are passed through unchanged, and the top address is legal.

## Structure
- `PROG_WORDS` and `MEM_LAT` defaults go in `lib/params.vh`, next to `WIDTH`, `ADDR_WIDTH`, `DATA_OFFSET` and `MEMORY_DEPTH`.
- State encodings are local parameters in the module.
- One sub-module, `rr_grant`: a 2-input round-robin picker with inputs `req[1:0]` and `last`, output `grant[1:0]`, purely combinational. The rest of the logic is in `mem_arbiter`.

## Test plan
- Fetch only: `i_req`, `i_addr=0`, with `mem` preloaded → `mem_addr=0` in `ISSUE`, `i_ack` 3 cycles after the request, `i_rdata` = `bank[0]`.
- Data write then read: write `0xDEADBEEF` to `PROG_WORDS+5`, then read it back → `mem_mode=1` for 2 cycles; `d_rdata=0xDEADBEEF`, `d_err=0`.
- Protected write to address 2 → `mem_mode` stays 0, `d_ack=1` with `d_err=1`, `bank[2]` unchanged.
- Both ports request continuously for 6 transactions → grant order i, d, i, d, i, d; acks every 4 cycles.
- Reset asserted during `WAIT` of a data read → all outputs return to reset values asynchronously, no `d_ack`; a re-issued request completes normally.
- `MEM_LAT=3`: fetch → ack exactly 5 cycles after the request.
